// File: rtl/ip_csum_pkg.sv
// ---------------------------------------------------------------------------
// ip_csum_pkg
//   Shared definitions for the IPv4 header checksum engine arbiter:
//   FSM state encoding, header geometry constants and the one's-complement
//   end-around fold used by the engine.
// ---------------------------------------------------------------------------
package ip_csum_pkg;

  localparam int IPV4_HDR_BITS = 160;  // 20-byte IPv4 header
  localparam int CSUM_BYTE_OFS = 10;   // checksum field occupies bytes 10-11
  localparam int ACCUM_WORDS   = 5;    // 32 bits (two halfwords) per ACCUM cycle
  localparam int ACC_W         = 20;   // 10 * 0xFFFF < 2^20, never overflows

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FOLD  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Two end-around carry steps are enough for a 20-bit accumulator:
  // the first leaves at most 0xFFFF + 0xF, the second cannot carry again.
  function automatic logic [15:0] fold_sum(input logic [ACC_W-1:0] acc);
    logic [16:0] s1;
    logic [16:0] s2;
    s1 = {1'b0, acc[15:0]} + 17'(acc[ACC_W-1:16]);
    s2 = {1'b0, s1[15:0]} + 17'(s1[16]);
    return s2[15:0];
  endfunction

endpackage

// File: rtl/ip_csum_rr_arbiter.sv
// ---------------------------------------------------------------------------
// ip_csum_rr_arbiter
//   Combinational rotate-priority selector. The requester at index ptr has
//   highest priority, then ptr+1, ... wrapping modulo NUM_REQ. The pointer
//   register itself lives in the parent.
//
// Ports:
//   req     in   NUM_REQ   request vector
//   ptr     in   IDX_W     current highest-priority index (< NUM_REQ)
//   any     out  1         at least one request is present
//   onehot  out  NUM_REQ   one-hot winner (0 when no request)
//   idx     out  IDX_W     binary index of the winner
// ---------------------------------------------------------------------------
module ip_csum_rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic                       any,
  output logic [NUM_REQ-1:0]         onehot,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] rot;
  int                 sel;

  // NOTE: every signal written here gets a default before any condition, so
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    // Rotate so bit 0 of rot is requester ptr; the lowest set bit wins.
    rot = NUM_REQ'({req, req} >> ptr);
    any = |req;
    sel = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) sel = int'(ptr) + k;
    end
    if (sel >= NUM_REQ) sel = sel - NUM_REQ;
    idx    = IDX_W'(sel);
    onehot = any ? (NUM_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/ip_csum_engine_arbiter.sv
// ---------------------------------------------------------------------------
// ip_csum_engine_arbiter
//   Shares one multi-cycle IPv4 header checksum engine among NUM_REQ
//   requesters. A round-robin arbiter grants one requester in IDLE, the
//   engine captures its 160-bit header, accumulates five 32-bit slices,
//   folds the sum and reports the checksum with a one-cycle done pulse.
//   One header every 8 cycles: capture, 5x ACCUM, FOLD, DONE.
//
// Ports:
//   AXI_ACLK   in   1                 clock
//   AXI_RESET  in   1                 synchronous active-high reset
//   req        in   NUM_REQ           per-requester request level
//   req_gen    in   NUM_REQ           1 = generate (checksum field as zero)
//   req_hdr    in   NUM_REQ*HDR_BITS  header i at [i*160 +: 160], byte 0 MSB
//   gnt        out  NUM_REQ           one-hot grant, capture through DONE
//   done       out  1                 one-cycle completion pulse
//   csum       out  16                ~folded_sum, valid with done
//   csum_ok    out  1                 folded_sum == 16'hFFFF, valid with done
//   bad_count  out  32                verify-failure counter
//
// Configuration:
//   IP_CSUM_BAD_COUNT_EN  when defined, bad_count counts verify failures
//                         (wraps at 2^32); otherwise it is tied to zero.
// ---------------------------------------------------------------------------
module ip_csum_engine_arbiter
  import ip_csum_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int HDR_BITS = IPV4_HDR_BITS
) (
  input  logic                         AXI_ACLK,
  input  logic                         AXI_RESET,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ-1:0]           req_gen,
  input  logic [NUM_REQ*HDR_BITS-1:0]  req_hdr,
  output logic [NUM_REQ-1:0]           gnt,
  output logic                         done,
  output logic [15:0]                  csum,
  output logic                         csum_ok,
  output logic [31:0]                  bad_count
);

  localparam int               IDX_W     = $clog2(NUM_REQ);
  localparam int               CSUM_MSB  = HDR_BITS - 1 - 8 * CSUM_BYTE_OFS;
  localparam logic [2:0]       WCNT_LAST = 3'(ACCUM_WORDS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_REQ - 1);

  state_t               state;
  state_t               state_nxt;

  logic                 arb_any;
  logic [NUM_REQ-1:0]   arb_onehot;
  logic [IDX_W-1:0]     arb_idx;
  logic [IDX_W-1:0]     ptr;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 capture;

  logic [HDR_BITS-1:0]  sel_hdr;
  logic                 sel_gen;
  logic [HDR_BITS-1:0]  hdr_q;
  logic [ACC_W-1:0]     acc;
  logic [2:0]           wcnt;
  logic [15:0]          folded;

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
  ip_csum_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req    (req),
    .ptr    (ptr),
    .any    (arb_any),
    .onehot (arb_onehot),
    .idx    (arb_idx)
  );

  assign capture = (state == IDLE) && arb_any;

  // Header/gen mux driven by the one-hot winner; in generate mode the
  // checksum field is forced to zero so the result is the value to insert.
  always_comb begin
    sel_hdr = '0;
    sel_gen = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_onehot[i]) begin
        sel_hdr = req_hdr[i*HDR_BITS +: HDR_BITS];
        sel_gen = req_gen[i];
      end
    end
    if (sel_gen) sel_hdr[CSUM_MSB -: 16] = 16'h0000;
  end

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge AXI_ACLK) begin
    if (AXI_RESET) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    unique case (state)
      IDLE:  if (arb_any) state_nxt = ACCUM;
      ACCUM: if (wcnt == WCNT_LAST) state_nxt = FOLD;
      FOLD:  state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Control registers: grant, RR pointer, result
  // -------------------------------------------------------------------------
  assign folded = fold_sum(acc);

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_RESET) begin
      gnt     <= '0;
      ptr     <= '0;
      csum    <= 16'h0000;
      csum_ok <= 1'b0;
    end else begin
      if (capture) gnt <= arb_onehot;
      if (state == FOLD) begin
        csum    <= ~folded;
        csum_ok <= (folded == 16'hFFFF);
      end
      if (state == DONE) begin
        gnt <= '0;
        ptr <= (gnt_idx == IDX_LAST) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Datapath: header shifter and accumulator
  // -------------------------------------------------------------------------
  // NOTE: datapath registers carry no reset; each is loaded at capture before
  // it is ever consumed, and the FSM (which is reset) gates every use.
  // The header shifts left 32 bits per ACCUM cycle, so the top 32 bits are
  // always the slice hdr[159-32*wcnt -: 32] of the captured header.
  always_ff @(posedge AXI_ACLK) begin
    if (capture) begin
      hdr_q   <= sel_hdr;
      gnt_idx <= arb_idx;
      acc     <= '0;
      wcnt    <= 3'd0;
    end else if (state == ACCUM) begin
      acc   <= acc + ACC_W'(hdr_q[HDR_BITS-1 -: 16]) + ACC_W'(hdr_q[HDR_BITS-17 -: 16]);
      hdr_q <= hdr_q << 32;
      wcnt  <= wcnt + 3'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Verify-failure counter
  // -------------------------------------------------------------------------
`ifdef IP_CSUM_BAD_COUNT_EN
  logic        gen_q;
  logic [31:0] bad_q;

  always_ff @(posedge AXI_ACLK) begin
    if (capture) gen_q <= sel_gen;
  end

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_RESET)                               bad_q <= '0;
    else if (state == DONE && !gen_q && !csum_ok) bad_q <= bad_q + 32'd1;
  end

  assign bad_count = bad_q;
`else
  assign bad_count = '0;
`endif

endmodule

// File: tb/tb_ip_csum_engine_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ip_csum_engine_arbiter
//   Self-checking bench: a transaction-level reference model predicts gnt,
//   done, csum, csum_ok and bad_count every cycle; directed tests pin known
//   headers, fairness order and reset-abort; a random phase exercises the
//   request/done handshake with valid and corrupted headers.
// ---------------------------------------------------------------------------
module tb_ip_csum_engine_arbiter;

  localparam int N  = 4;
  localparam int HB = 160;

  localparam logic [159:0] GOOD = 160'h4500_0073_0000_4000_4011_B861_C0A8_0001_C0A8_00C7;
  localparam logic [159:0] BAD  = 160'h4500_0073_0000_4000_4011_B862_C0A8_0001_C0A8_00C7;

`ifdef IP_CSUM_BAD_COUNT_EN
  localparam int BAD_AFTER_CORRUPT = 1;
`else
  localparam int BAD_AFTER_CORRUPT = 0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req;
  logic [N-1:0]      req_gen;
  logic [N*HB-1:0]   req_hdr;
  logic [HB-1:0]     hdr_arr [N];
  logic [N-1:0]      gnt;
  logic              done;
  logic [15:0]       csum;
  logic              csum_ok;
  logic [31:0]       bad_count;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) req_hdr[i*HB +: HB] = hdr_arr[i];
  end

  ip_csum_engine_arbiter #(.NUM_REQ(N), .HDR_BITS(HB)) dut (
    .AXI_ACLK  (clk),
    .AXI_RESET (rst),
    .req       (req),
    .req_gen   (req_gen),
    .req_hdr   (req_hdr),
    .gnt       (gnt),
    .done      (done),
    .csum      (csum),
    .csum_ok   (csum_ok),
    .bad_count (bad_count)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // ---------------------------------------------------------------- model --
  // RFC 1071 checksum: sum ten halfwords, fold carries until none remain.
  // Returns {ok, csum}.
  function automatic logic [16:0] ref_result(input logic [159:0] h, input bit g);
    int unsigned s;
    logic [15:0] w;
    s = 0;
    for (int i = 0; i < 10; i++) begin
      w = 16'(h >> (16 * (9 - i)));
      if (g && i == 5) w = 16'h0000;
      s += w;
    end
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    return {s[15:0] == 16'hFFFF, ~s[15:0]};
  endfunction

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic int oh2idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v == (N'(1) << i)) return i;
    return -1;
  endfunction

  function automatic logic [159:0] make_hdr(input bit valid);
    logic [159:0] h;
    logic [16:0]  r;
    for (int i = 0; i < 5; i++) h[32*i +: 32] = $urandom();
    if (valid) begin
      r = ref_result(h, 1'b1);
      h[79:64] = r[15:0];
    end
    return h;
  endfunction

  // Transaction model: an operation occupies cycles 1..7 after its IDLE
  // sample; gnt for all seven, done and the new result in cycle 7.
  bit           m_busy = 1'b0;
  int           m_phase, m_idx, m_ptr;
  bit           m_gen;
  logic [16:0]  m_res;
  logic [N-1:0] exp_gnt = '0;
  logic         exp_done = 1'b0;
  logic [15:0]  exp_csum = '0;
  logic         exp_ok = 1'b0;
  logic [31:0]  exp_bad = '0;
  logic [N-1:0] last_done_gnt = '0;

  always @(posedge clk) begin
    last_done_gnt = exp_done ? exp_gnt : '0;
    if (rst) begin
      m_busy = 1'b0; m_phase = 0; m_ptr = 0;
      exp_gnt = '0; exp_done = 1'b0; exp_csum = '0; exp_ok = 1'b0; exp_bad = '0;
    end else if (!m_busy) begin
      if (|req) begin
        m_idx   = rr_pick(req, m_ptr);
        m_gen   = req_gen[m_idx];
        m_res   = ref_result(hdr_arr[m_idx], m_gen);
        m_busy  = 1'b1;
        m_phase = 1;
        exp_gnt = N'(1) << m_idx;
      end
      exp_done = 1'b0;
    end else begin
      if (m_phase == 7) begin
        m_busy  = 1'b0;
        exp_gnt = '0;
        m_ptr   = (m_idx + 1) % N;
`ifdef IP_CSUM_BAD_COUNT_EN
        if (!m_gen && !m_res[16]) exp_bad = exp_bad + 1;
`endif
      end else begin
        m_phase++;
        if (m_phase == 7) begin
          exp_csum = m_res[15:0];
          exp_ok   = m_res[16];
        end
      end
      exp_done = m_busy && (m_phase == 7);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("gnt", 32'(gnt), 32'(exp_gnt));
      check("done", 32'(done), 32'(exp_done));
      check("csum", 32'(csum), 32'(exp_csum));
      check("csum_ok", 32'(csum_ok), 32'(exp_ok));
      check("bad_count", bad_count, exp_bad);
    end
  end

  // ------------------------------------------------------------ stimulus --
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request from idle, check latency and the literal result.
  task automatic run_single(input int idx, input logic [159:0] h, input bit g,
                            input logic [15:0] want_csum, input int want_ok,
                            input string tag);
    bit seen;
    seen = 1'b0;
    hdr_arr[idx] = h;
    req_gen[idx] = g;
    req[idx]     = 1'b1;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (k == 1) check({tag, " gnt@1"}, 32'(gnt), 32'(N'(1) << idx));
      if (done) begin
        seen = 1'b1;
        check({tag, " latency"}, k, 7);
        check({tag, " gnt@done"}, 32'(gnt), 32'(N'(1) << idx));
        check({tag, " csum"}, 32'(csum), 32'(want_csum));
        if (want_ok >= 0) check({tag, " csum_ok"}, 32'(csum_ok), want_ok);
      end
    end
    if (!seen) check({tag, " done timeout"}, 0, 1);
    tick();
    req[idx] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [16:0] r;
    logic [N-1:0] drop;
    int n_done;
    int order [6];
    int tdone [6];
    logic [N-1:0] got [2];

    rst = 1'b1; req = '0; req_gen = '0;
    for (int i = 0; i < N; i++) hdr_arr[i] = '0;

    // Pin the model against hand-computed values.
    r = ref_result(GOOD, 1'b0);  check("model good", 32'(r), 32'h1_0000);
    r = ref_result(GOOD, 1'b1);  check("model gen", 32'(r[15:0]), 32'hB861);
    r = ref_result(BAD, 1'b0);   check("model bad", 32'(r), 32'h0_FFFE);
    r = ref_result('1, 1'b0);    check("model all_ff", 32'(r), 32'h1_0000);

    tick();
    cmp_en = 1'b1;
    tick();
    @(negedge clk);
    check("reset gnt", 32'(gnt), 0);
    check("reset done", 32'(done), 0);
    check("reset csum", 32'(csum), 0);
    check("reset csum_ok", 32'(csum_ok), 0);
    check("reset bad_count", bad_count, 0);
    tick();
    rst = 1'b0;

    // One's-complement arithmetic on a correct header folds to 0xFFFF;
    // a checksum field one higher wraps past 0xFFFF to 0x0001.
    run_single(0, GOOD, 1'b0, 16'h0000, 1, "verify_good");
    run_single(2, GOOD, 1'b1, 16'hB861, -1, "generate");
    run_single(1, BAD, 1'b0, 16'hFFFE, 0, "verify_bad");
    @(negedge clk);
    check("bad_count after corrupt", bad_count, BAD_AFTER_CORRUPT);
    tick();
    run_single(3, '1, 1'b0, 16'h0000, 1, "all_ff");

    // Fairness: all four request, each drops after its done; after the
    // grant to 3 the requests become 1001 and the pointer has wrapped to 0.
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      hdr_arr[i] = make_hdr(1'b1);
      req_gen[i] = 1'b0;
    end
    req = 4'b1111;
    n_done = 0;
    for (int c = 0; c < 100 && n_done < 6; c++) begin
      @(negedge clk);
      drop = '0;
      if (done) begin
        order[n_done] = oh2idx(gnt);
        tdone[n_done] = c;
        n_done++;
        drop = gnt;
      end
      tick();
      if (drop != '0) begin
        req = req & ~drop;
        if (drop == 4'b1000 && n_done == 4) req = 4'b1001;
      end
    end
    req = '0;
    check("fair done count", n_done, 6);
    if (n_done == 6) begin
      check("fair order 0", order[0], 0);
      check("fair order 1", order[1], 1);
      check("fair order 2", order[2], 2);
      check("fair order 3", order[3], 3);
      check("fair order 4", order[4], 0);
      check("fair order 5", order[5], 3);
      check("fair first done", tdone[0], 7);
      for (int i = 1; i < 6; i++) check("fair done spacing", tdone[i] - tdone[i-1], 8);
    end

    // Reset during ACCUM wcnt=2 of a grant to 2, with the pointer at 1.
    run_single(0, GOOD, 1'b0, 16'h0000, 1, "ptr_setup");
    hdr_arr[2] = GOOD; req_gen[2] = 1'b0; req[2] = 1'b1;
    tick(); tick(); tick();
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid gnt before", 32'(gnt), 32'b0100);
    tick();
    rst = 1'b0;
    req = 4'b0011;
    hdr_arr[0] = make_hdr(1'b1);
    hdr_arr[1] = BAD;
    req_gen = '0;
    @(negedge clk);
    check("rst_mid gnt dropped", 32'(gnt), 0);
    check("rst_mid no done", 32'(done), 0);
    tick();
    @(negedge clk);
    check("rst_mid ptr cleared", 32'(gnt), 32'b0001);
    tick();
    req[0] = 1'b0;
    n_done = 0;
    for (int c = 0; c < 40 && n_done < 2; c++) begin
      @(negedge clk);
      if (done) begin
        got[n_done] = gnt;
        n_done++;
      end
    end
    tick();
    req = '0;
    check("rst_mid done count", n_done, 2);
    if (n_done == 2) begin
      check("rst_mid dropped req still done", 32'(got[0]), 32'b0001);
      check("rst_mid req1 granted", 32'(got[1]), 32'b0010);
    end

    // Random handshake traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst = ($urandom_range(0, 599) == 0);
      for (int i = 0; i < N; i++) begin
        if (last_done_gnt[i]) begin
          if ($urandom_range(0, 7) != 0) req[i] = 1'b0;
        end else if (req[i] && exp_gnt[i]) begin
          hdr_arr[i] = make_hdr($urandom_range(0, 1) == 1);
          if ($urandom_range(0, 39) == 0) req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 5) == 0) begin
          hdr_arr[i] = make_hdr($urandom_range(0, 1) == 1);
          req_gen[i] = 1'($urandom_range(0, 1));
          req[i]     = 1'b1;
        end
      end
    end
    rst = 1'b0;
    req = '0;
    repeat (10) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
